// File: rtl/register_32bit.sv
// General-purpose WIDTH-bit storage register with a synchronous write enable
// and an asynchronous active-low clear; q_o is driven straight from the flops.
module register_32bit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q;

    // Clear wins over write; with en_i low d_i is never looked at, so X/Z there cannot leak in.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            q <= RST_VAL;
        end else if (en_i) begin
            q <= d_i;
        end
    end

    assign q_o = q;

endmodule

// File: tb/tb_register_32bit.sv
// Directed bench for register_32bit: stimulus pushes expected q_o values into a
// queue and a separate monitor pops and compares them when a sample is signalled.
module tb_register_32bit;

    logic        clk_i;
    logic        nrst_i;
    logic        en_i;
    logic [31:0] d_i;
    logic [31:0] q_o;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   vectors;
    int   miscompares;

    register_32bit #(
        .WIDTH  (32),
        .RST_VAL(32'h0000_0000)
    ) dut (
        .clk_i (clk_i),
        .nrst_i(nrst_i),
        .en_i  (en_i),
        .d_i   (d_i),
        .q_o   (q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Monitor: drains every expectation queued before the sample strobe.
    initial begin
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (q_o !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: q_o=%h expected %h", e.name, q_o, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        -> chk_ev;
    endtask

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic apply(input logic rst_n, input logic en, input logic [31:0] d,
                         input string name, input logic [31:0] exp);
        @(negedge clk_i);
        nrst_i = rst_n;
        en_i   = en;
        d_i    = d;
        @(posedge clk_i);
        #1;
        expect_now(name, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst_i      = 1'b0;
        en_i        = 1'b0;
        d_i         = 32'hDEAD_BEEF;
        @(posedge clk_i);
        #1;
        expect_now("reset", 32'h0000_0000);

        apply(1'b1, 1'b1, 32'h0000_0011, "write1", 32'h0000_0011);
        apply(1'b1, 1'b1, 32'h1234_5678, "write2", 32'h1234_5678);
        apply(1'b1, 1'b0, 32'hFFFF_FFFF, "hold1", 32'h1234_5678);
        apply(1'b1, 1'b0, 32'hFFFF_FFFF, "hold2", 32'h1234_5678);
        apply(1'b1, 1'b0, 32'hxxxx_xxxx, "hold_x", 32'h1234_5678);

        // Reset asserted with a write pending: clear must land before any edge and stick.
        @(negedge clk_i);
        nrst_i = 1'b0;
        en_i   = 1'b1;
        d_i    = 32'hAAAA_5555;
        #1;
        expect_now("rst_async1", 32'h0000_0000);
        @(posedge clk_i);
        #1;
        expect_now("rst_beats_wr", 32'h0000_0000);

        apply(1'b1, 1'b1, 32'hCAFE_BABE, "recover_wr", 32'hCAFE_BABE);
        apply(1'b1, 1'b0, 32'hBADF_00D1, "recover_hold", 32'hCAFE_BABE);
        apply(1'b1, 1'b1, 32'h0F0F_0F0F, "recover_wr2", 32'h0F0F_0F0F);

        // Mid-cycle reset pulse while holding 0x0F0F0F0F.
        @(negedge clk_i);
        en_i = 1'b0;
        d_i  = 32'h1111_2222;
        #1;
        nrst_i = 1'b0;
        #1;
        expect_now("rst_pulse", 32'h0000_0000);
        #1;
        nrst_i = 1'b1;
        #1;
        expect_now("rst_release", 32'h0000_0000);
        @(posedge clk_i);
        #1;
        expect_now("post_rst_hold", 32'h0000_0000);

        apply(1'b1, 1'b1, 32'h1357_9BDF, "post_rst_wr", 32'h1357_9BDF);
        apply(1'b1, 1'b1, 32'hFFFF_FFFF, "b2b_wr1", 32'hFFFF_FFFF);
        apply(1'b1, 1'b1, 32'h0000_0000, "b2b_wr2", 32'h0000_0000);

        #3;
        if (exp_q.size() != 0) begin
            miscompares += exp_q.size();
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
